axi_rd_sched: RTL
=================

# axi_rd_sched

Round-robin read-command scheduler that shares the single AXI4 read controller (`AXI4_read_ctrl`) among `NUM_REQ` NPU load clients (weight, feature, bias, …).
- Accepts one read command per requester through a valid/ready handshake, sequences the controller's start/busy protocol, and reports per-requester completion with error status.
- Relocates the controller's zero-based SRAM write stream onto the granted requester's SRAM base and select line.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters
- `REQ_ID_WIDTH`, 2, `clog2(NUM_REQ)`
- `AXI_ADDR_WIDTH`, 32, byte address width
- `AXI_DATA_WIDTH`, 32, beat width; `STRB_W = AXI_DATA_WIDTH/8`
- `TRAN_BYTE_NUM_WIDTH`, 16, command byte-length width
- `SRAM_ADDR_WIDTH`, 32, SRAM word address width

Ports:
- `clk` in 1, clock
- `rst_n` in 1, asynchronous, active-low reset
- `req_valid_i` in NUM_REQ, command valid per requester
- `req_ready_o` out NUM_REQ, command accepted (one-hot pulse)
- `req_addr_i` in NUM_REQ*AXI_ADDR_WIDTH, flattened byte address, requester k at slice k
- `req_len_i` in NUM_REQ*TRAN_BYTE_NUM_WIDTH, flattened byte count
- `req_sram_base_i` in NUM_REQ*SRAM_ADDR_WIDTH, flattened SRAM word base
- `done_o` out NUM_REQ, one-cycle completion pulse
- `done_err_o` out 1, error status, valid with any `done_o` bit
- `grant_id_o` out REQ_ID_WIDTH, current owner
- `busy_o` out 1, command in flight
- `rd_base_addr_o` out AXI_ADDR_WIDTH, to controller base address
- `rd_byte_num_o` out TRAN_BYTE_NUM_WIDTH, to controller byte count
- `rd_start_o` out 1, one-cycle start pulse
- `rd_busy_i` in 1, controller busy
- `rd_error_i` in 1, controller sticky error
- `rd_sram_addr_i` in SRAM_ADDR_WIDTH, controller SRAM word address
- `rd_sram_valid_i` in STRB_W, controller byte enables
- `rd_sram_data_i` in AXI_DATA_WIDTH, controller data
- `sram_sel_o` out NUM_REQ, one-hot SRAM select
- `sram_addr_o` out SRAM_ADDR_WIDTH, SRAM word address
- `sram_wstrb_o` out STRB_W, SRAM byte enables
- `sram_data_o` out AXI_DATA_WIDTH, SRAM data

## Operation
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, DRAIN, RESP.
- **IDLE:** if any `req_valid_i`, grant the first valid index at or after `rr_ptr`, searching circularly.
  - Same cycle: pulse `req_ready_o[g]`; latch addr, len and sram_base; set `grant_id_o = g`.
  - If len == 0: go to RESP with error = 0; no controller start is issued.
  - Otherwise go to START.
- **START:** assert `rd_start_o` for exactly one cycle with the latched addr/len, then go to WAIT_BUSY.
- **WAIT_BUSY:** wait for `rd_busy_i = 1`, then go to WAIT_DONE.
- **WAIT_DONE:** wait for `rd_busy_i = 0`, then go to DRAIN.
- **DRAIN:** exactly one cycle. The controller's final SRAM beat arrives in the cycle after busy falls. Sample `rd_error_i`, OR it into `err_acc`, then go to RESP.
- **RESP:** pulse `done_o[g]`, drive `done_err_o = err_acc`, set `rr_ptr = g+1` (mod NUM_REQ), clear `err_acc`, go to IDLE.
- `busy_o` = state != IDLE.
- SRAM relocation is registered, 1 cycle:
  - `sram_addr_o = sram_base + seg_word_off + rd_sram_addr_i`, modulo 2^SRAM_ADDR_WIDTH.
  - `sram_wstrb_o = rd_sram_valid_i`; `sram_data_o = rd_sram_data_i`.
  - `sram_sel_o = onehot(g)` when `rd_sram_valid_i != 0`, else 0.
- Requesters must hold command fields stable only until their `req_ready_o`.
- A requester whose valid drops before grant is skipped without penalty.

## Timing
- Reset: all outputs 0; state IDLE; `rr_ptr = 0`; `err_acc = 0`.
- Cycle counts with a controller that rises busy one cycle after start:
  - Grant to `rd_start_o`: 1 cycle.
  - `rd_busy_i` fall to `done_o`: 2 cycles.
  - Zero-length command: grant to `done_o` is 1 cycle.
- Back-to-back: the next grant may occur in the cycle after RESP. Minimum gap between commands is 1 IDLE cycle.
- Simultaneous requests: exactly one grant per IDLE cycle; round-robin guarantees each valid requester waits at most NUM_REQ-1 commands.
- A `req_valid_i` asserted in the same cycle as RESP is not eligible until the following IDLE cycle.
- Reset mid-operation aborts immediately with no done pulse. The controller shares `rst_n`.

## Configuration
- Macro: `AXI_RD_SCHED_SPLIT_4K_EN`.
- **Defined:** each command is split into segments that never cross a 4 KB address boundary.
  - Segment length = min(remaining, 4096 − addr[11:0]).
  - Each segment runs START → DRAIN; DRAIN returns to START while remaining > 0.
  - `seg_word_off` = (segment addr − word-aligned command addr) / STRB_W.
  - `err_acc` ORs across segments. A single `done_o` is issued after the last segment.
- **Undefined:** one segment per command; `seg_word_off` is fixed at 0; the split logic is absent.

## Structure
- Shared package `npu_axi_pkg`:
  - FSM state enum `axi_rd_sched_state_t`.
  - `AXI_4K_BOUNDARY = 4096`.
  - `clog2` function.
- One natural sub-module, `rr_arbiter`: NUM_REQ request vector + pointer in, one-hot grant + index out, purely combinational.

## Test plan
- Single request, requester 1, addr 0x1000, len 64, sram_base 0x40:
  - One `rd_start_o`; `sram_addr_o` runs 0x40..0x4F with `sram_sel_o = 0b0010`.
  - `done_o[1]` 2 cycles after busy falls; `done_err_o = 0`.
- All four valid together, `rr_ptr = 0`: grants in order 0,1,2,3. Requester 0 re-asserting after its done is served after 3.
- len = 0 from requester 2: `done_o[2]` one cycle after grant; no `rd_start_o`.
- Controller error: drive `rd_error_i = 1` before busy falls → `done_err_o = 1`. The next command reports 0.
- With `AXI_RD_SCHED_SPLIT_4K_EN`, addr 0x0F80, len 0x200:
  - Two starts: (0x0F80, 0x80) then (0x1000, 0x180).
  - Second segment's SRAM addresses begin at base + 0x20.
- Reset asserted in WAIT_DONE: all outputs 0 at once; a new request after release is granted normally.

Source files
------------

// File: rtl/npu_axi_pkg.sv
// npu_axi_pkg
// Shared definitions for the NPU AXI read path:
//   axi_rd_sched_state_t : scheduler FSM state encoding
//   AXI_4K_BOUNDARY      : AXI burst page size in bytes
//   clog2()              : elaboration-time ceil(log2) helper

package npu_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_DRAIN,
        ST_RESP
    } axi_rd_sched_state_t;

    localparam int AXI_4K_BOUNDARY = 4096;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin picker: grants the first set request
// at or after ptr, searching circularly.
// Ports:
//   req         in  NUM_REQ   request vector
//   ptr         in  ID_WIDTH  highest-priority index
//   grant       out NUM_REQ   one-hot grant (zero when no request)
//   grant_idx   out ID_WIDTH  index of the granted request
//   grant_valid out 1         any request granted

module rr_arbiter
    import npu_axi_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_idx,
    output logic                grant_valid
);

    logic [ID_WIDTH-1:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_WIDTH'((int'(ptr) + i) % NUM_REQ);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/axi_rd_sched.sv
// axi_rd_sched
// Round-robin scheduler sharing one AXI4 read controller among NUM_REQ
// load clients. Sequences the controller start/busy handshake, reports
// per-requester completion with error status, and relocates the
// controller's zero-based SRAM write stream onto the owner's SRAM base.
//
// Optional feature macro: AXI_RD_SCHED_SPLIT_4K_EN
//   defined   : commands are split into segments never crossing 4 KB
//   undefined : one controller command per request
//
// Ports:
//   clk, rst_n (async, active-low)
//   req_valid_i / req_ready_o        per-requester command handshake
//   req_addr_i / req_len_i / req_sram_base_i   flattened command fields
//   done_o / done_err_o              completion pulse and error status
//   grant_id_o, busy_o               current owner, command in flight
//   rd_base_addr_o / rd_byte_num_o / rd_start_o   controller command
//   rd_busy_i / rd_error_i           controller status
//   rd_sram_addr_i / rd_sram_valid_i / rd_sram_data_i   controller SRAM stream
//   sram_sel_o / sram_addr_o / sram_wstrb_o / sram_data_o   relocated stream

module axi_rd_sched
    import npu_axi_pkg::*;
#(
    parameter int  NUM_REQ             = 4,
    parameter int  REQ_ID_WIDTH        = clog2(NUM_REQ),
    parameter int  AXI_ADDR_WIDTH      = 32,
    parameter int  AXI_DATA_WIDTH      = 32,
    parameter int  TRAN_BYTE_NUM_WIDTH = 16,
    parameter int  SRAM_ADDR_WIDTH     = 32,
    localparam int STRB_W              = AXI_DATA_WIDTH / 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_REQ-1:0]                     req_valid_i,
    output logic [NUM_REQ-1:0]                     req_ready_o,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]      req_addr_i,
    input  logic [NUM_REQ*TRAN_BYTE_NUM_WIDTH-1:0] req_len_i,
    input  logic [NUM_REQ*SRAM_ADDR_WIDTH-1:0]     req_sram_base_i,
    output logic [NUM_REQ-1:0]                     done_o,
    output logic                                   done_err_o,
    output logic [REQ_ID_WIDTH-1:0]                grant_id_o,
    output logic                                   busy_o,
    output logic [AXI_ADDR_WIDTH-1:0]              rd_base_addr_o,
    output logic [TRAN_BYTE_NUM_WIDTH-1:0]         rd_byte_num_o,
    output logic                                   rd_start_o,
    input  logic                                   rd_busy_i,
    input  logic                                   rd_error_i,
    input  logic [SRAM_ADDR_WIDTH-1:0]             rd_sram_addr_i,
    input  logic [STRB_W-1:0]                      rd_sram_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0]              rd_sram_data_i,
    output logic [NUM_REQ-1:0]                     sram_sel_o,
    output logic [SRAM_ADDR_WIDTH-1:0]             sram_addr_o,
    output logic [STRB_W-1:0]                      sram_wstrb_o,
    output logic [AXI_DATA_WIDTH-1:0]              sram_data_o
);

    axi_rd_sched_state_t state, state_nxt;

    logic [AXI_ADDR_WIDTH-1:0]      req_addr_arr [NUM_REQ];
    logic [TRAN_BYTE_NUM_WIDTH-1:0] req_len_arr  [NUM_REQ];
    logic [SRAM_ADDR_WIDTH-1:0]     req_base_arr [NUM_REQ];

    logic [NUM_REQ-1:0]             arb_grant;
    logic [REQ_ID_WIDTH-1:0]        arb_idx;
    logic                           arb_valid;

    logic [REQ_ID_WIDTH-1:0]        rr_ptr;
    logic [REQ_ID_WIDTH-1:0]        grant_q;
    logic [NUM_REQ-1:0]             grant_onehot;
    // Current segment address and bytes still to fetch for the command.
    logic [AXI_ADDR_WIDTH-1:0]      cur_addr_q;
    logic [TRAN_BYTE_NUM_WIDTH-1:0] cur_len_q;
    logic [SRAM_ADDR_WIDTH-1:0]     sram_base_q;
    logic                           err_acc;

    logic [TRAN_BYTE_NUM_WIDTH-1:0] seg_len;
    logic [SRAM_ADDR_WIDTH-1:0]     seg_word_off;
    logic                           last_seg;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_addr_arr[k] = req_addr_i[k*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        assign req_len_arr[k]  = req_len_i[k*TRAN_BYTE_NUM_WIDTH +: TRAN_BYTE_NUM_WIDTH];
        assign req_base_arr[k] = req_sram_base_i[k*SRAM_ADDR_WIDTH +: SRAM_ADDR_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (REQ_ID_WIDTH)
    ) u_rr_arbiter (
        .req         (req_valid_i),
        .ptr         (rr_ptr),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    assign grant_onehot = NUM_REQ'(1) << grant_q;

`ifdef AXI_RD_SCHED_SPLIT_4K_EN
    localparam int STRB_SHIFT = clog2(STRB_W);

    logic [AXI_ADDR_WIDTH-1:0] cmd_addr_q;
    logic [12:0]               page_room;

    // Bytes left before the next 4 KB page; a segment never exceeds it.
    always_comb begin
        page_room = 13'(AXI_4K_BOUNDARY) - {1'b0, cur_addr_q[11:0]};
        seg_len   = (cur_len_q < TRAN_BYTE_NUM_WIDTH'(page_room)) ?
                    cur_len_q : TRAN_BYTE_NUM_WIDTH'(page_room);
    end

    assign last_seg = (cur_len_q == seg_len);

    // The controller restarts its SRAM addresses at 0 for every segment, so
    // later segments are shifted by their word distance from the command start.
    assign seg_word_off = SRAM_ADDR_WIDTH'((cur_addr_q -
                          (cmd_addr_q & ~AXI_ADDR_WIDTH'(STRB_W - 1))) >> STRB_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_addr_q <= '0;
        end else if (state == ST_IDLE && arb_valid) begin
            cmd_addr_q <= req_addr_arr[arb_idx];
        end
    end
`else
    assign seg_len      = cur_len_q;
    assign last_seg     = 1'b1;
    assign seg_word_off = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready_o = '0;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    req_ready_o = arb_grant;
                    state_nxt   = (req_len_arr[arb_idx] == '0) ? ST_RESP : ST_START;
                end
            end
            ST_START:     state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (rd_busy_i)  state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!rd_busy_i) state_nxt = ST_DRAIN;
            // One extra cycle so the controller's last SRAM beat lands first.
            ST_DRAIN:     state_nxt = last_seg ? ST_RESP : ST_START;
            ST_RESP:      state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            grant_q     <= '0;
            cur_addr_q  <= '0;
            cur_len_q   <= '0;
            sram_base_q <= '0;
            err_acc     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_q     <= arb_idx;
                        cur_addr_q  <= req_addr_arr[arb_idx];
                        cur_len_q   <= req_len_arr[arb_idx];
                        sram_base_q <= req_base_arr[arb_idx];
                    end
                end
                ST_DRAIN: begin
                    err_acc <= err_acc | rd_error_i;
`ifdef AXI_RD_SCHED_SPLIT_4K_EN
                    cur_addr_q <= cur_addr_q + AXI_ADDR_WIDTH'(seg_len);
                    cur_len_q  <= cur_len_q - seg_len;
`endif
                end
                ST_RESP: begin
                    err_acc <= 1'b0;
                    rr_ptr  <= (grant_q == REQ_ID_WIDTH'(NUM_REQ - 1)) ?
                               '0 : grant_q + REQ_ID_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign rd_start_o     = (state == ST_START);
    assign rd_base_addr_o = cur_addr_q;
    assign rd_byte_num_o  = seg_len;
    assign busy_o         = (state != ST_IDLE);
    assign grant_id_o     = grant_q;
    assign done_o         = (state == ST_RESP) ? grant_onehot : '0;
    assign done_err_o     = (state == ST_RESP) && err_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_sel_o   <= '0;
            sram_addr_o  <= '0;
            sram_wstrb_o <= '0;
            sram_data_o  <= '0;
        end else begin
            sram_sel_o   <= (|rd_sram_valid_i) ? grant_onehot : '0;
            sram_addr_o  <= sram_base_q + seg_word_off + rd_sram_addr_i;
            sram_wstrb_o <= rd_sram_valid_i;
            sram_data_o  <= rd_sram_data_i;
        end
    end

endmodule
